// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_pkg
// Description : Shared types for the store write buffer and lane aligner.
// Revision    : 1.0 - initial release
// ============================================================================
package store_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Widest supported address; entries hold the word address zero-extended to this.
  localparam int MAX_AW  = 64;
  localparam int MAX_WAW = MAX_AW - 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic [MAX_WAW-1:0] word_addr;
    logic [31:0]        data;
    logic [3:0]         be;
    logic               valid;
  } store_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : store_lane_align
// Description : Size/address to byte-enable, lane-replicated data and legality.
// Revision    : 1.0 - initial release
// ============================================================================
module store_lane_align
  import store_pkg::*;
(
  input  logic [1:0]  i_addr_lsb,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_data,
  output logic        o_legal
);

  always_comb begin
    o_be    = 4'b0000;
    o_data  = 32'h0;
    o_legal = 1'b0;
    case (i_size)
      SZ_B: begin
        o_be    = 4'b0001 << i_addr_lsb;
        o_data  = {4{i_data[7:0]}};
        o_legal = 1'b1;
      end
      SZ_H: begin
        o_be    = i_addr_lsb[1] ? 4'b1100 : 4'b0011;
        o_data  = {2{i_data[15:0]}};
        o_legal = ~i_addr_lsb[0];
      end
      SZ_W: begin
        o_be    = 4'b1111;
        o_data  = i_data;
        o_legal = (i_addr_lsb == 2'b00);
      end
      default: begin
        o_be    = 4'b0000;
        o_data  = 32'h0;
        o_legal = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_write_buffer
// Description : In-order store buffer draining to data memory over req/ack.
// Revision    : 1.0 - initial release
// ============================================================================
module store_write_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write_enable,
  input  logic [AW-1:0] address,
  input  logic [31:0]   write_data,
  input  logic [1:0]    st_size,
  output logic          full,
  output logic          empty,
  output logic          misalign_err,
  output logic [AW-1:0] err_addr,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hazard,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack
);

  localparam int         PW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] c_full_count = (PW+1)'(DEPTH);

  store_entry_t   r_entries [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW:0]    r_count;
  drain_state_e   r_state;
  logic           r_misalign_err;
  logic [AW-1:0]  r_err_addr;
  logic           r_mem_req;
  logic [AW-1:0]  r_mem_addr;
  logic [31:0]    r_mem_wdata;
  logic [3:0]     r_mem_be;

  logic [3:0]         w_be;
  logic [31:0]        w_data;
  logic               w_legal;
  logic               w_enq;
  logic               w_deq;
  logic [MAX_WAW-1:0] w_st_waddr;
  logic [MAX_WAW-1:0] w_ld_waddr;
  logic               w_hazard;
  logic               w_unused_ld_lsb;

  store_lane_align u_align (
    .i_addr_lsb (address[1:0]),
    .i_size     (st_size),
    .i_data     (write_data),
    .o_be       (w_be),
    .o_data     (w_data),
    .o_legal    (w_legal)
  );

  assign full            = (r_count == c_full_count);
  assign empty           = (r_count == '0);
  assign w_enq           = write_enable && !full && w_legal;
  assign w_deq           = (r_state == REQ) && mem_ack;
  assign w_st_waddr      = MAX_WAW'(address[AW-1:2]);
  assign w_ld_waddr      = MAX_WAW'(ld_addr[AW-1:2]);
  assign w_unused_ld_lsb = ^ld_addr[1:0];

  // Storage, pointers, count and the reject reporting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_misalign_err <= 1'b0;
      r_err_addr     <= '0;
    end else begin
      if (w_enq) begin
        r_entries[r_wr_ptr] <= '{word_addr: w_st_waddr, data: w_data,
                                 be: w_be, valid: 1'b1};
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_deq) begin
        r_entries[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_misalign_err <= write_enable && !w_legal;
      if (write_enable && !w_legal) r_err_addr <= address;
    end
  end

  // Drain FSM: at least one IDLE cycle separates consecutive requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_count != '0) begin
            r_mem_addr  <= {r_entries[r_rd_ptr].word_addr[AW-3:0], 2'b00};
            r_mem_wdata <= r_entries[r_rd_ptr].data;
            r_mem_be    <= r_entries[r_rd_ptr].be;
            r_mem_req   <= 1'b1;
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_entries[i].valid && (r_entries[i].word_addr == w_ld_waddr)) w_hazard = 1'b1;
    end
  end

  assign ld_hazard    = w_hazard;
  assign misalign_err = r_misalign_err;
  assign err_addr     = r_err_addr;
  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_be       = r_mem_be;

endmodule
`default_nettype wire
